// File: rtl/hilo_pkg.sv
// hilo_pkg: shared operation encoding and divider state type for hilo_unit.
package hilo_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_MULT  = 3'd0;
  localparam logic [OP_W-1:0] OP_MULTU = 3'd1;
  localparam logic [OP_W-1:0] OP_DIV   = 3'd2;
  localparam logic [OP_W-1:0] OP_DIVU  = 3'd3;
  localparam logic [OP_W-1:0] OP_MTHI  = 3'd4;
  localparam logic [OP_W-1:0] OP_MTLO  = 3'd5;
  // Codes 6 and 7 are reserved and behave as no-ops.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/hilo_unit_div_step.sv
// div_restoring_step: one combinational iteration of an unsigned restoring
// divider. Shifts the next dividend bit into the partial remainder, tries to
// subtract the divisor, and records the outcome as the new quotient LSB.
module div_restoring_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rem,
  input  logic [N-1:0] quo,
  input  logic [N-1:0] dvs,
  output logic [N-1:0] rem_next,
  output logic [N-1:0] quo_next
);

  logic [N:0] shifted;
  logic [N:0] trial;
  logic       borrow;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in N+1 bits and bit N of the trial difference is a clean borrow flag.
  assign shifted  = {rem, quo[N-1]};
  assign trial    = shifted - {1'b0, dvs};
  assign borrow   = trial[N];

  assign rem_next = borrow ? shifted[N-1:0] : trial[N-1:0];
  assign quo_next = {quo[N-2:0], ~borrow};

endmodule

// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO registers fed by an external multiplier,
// MTHI/MTLO writes, and an optional multi-cycle restoring divider.
// Build option: define HILO_DIV_EN to include the divider; without it
// DIV/DIVU complete in one cycle and leave HI/LO untouched.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int N = 32
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Start,
  input  logic [OP_W-1:0] Op,
  input  logic [N-1:0]    A,
  input  logic [N-1:0]    B,
  input  logic [N-1:0]    ProdHi,
  input  logic [N-1:0]    ProdLo,
  output logic            MulSigned,
  output logic            Busy,
  output logic            Done,
  output logic            DivByZero,
  output logic [N-1:0]    Hi,
  output logic [N-1:0]    Lo
);

  // The multiplier sits upstream and must see the signedness in the same
  // cycle as its operands, so this select is purely combinational.
  assign MulSigned = (Op == OP_MULT);

`ifdef HILO_DIV_EN

  localparam int CW = $clog2(N + 1);

  state_t        state;
  logic [CW-1:0] count;
  logic [N-1:0]  rem_q;
  logic [N-1:0]  quo_q;
  logic [N-1:0]  dvs_q;
  logic          neg_quo;
  logic          neg_rem;

  logic          div_signed;
  logic          a_neg;
  logic          b_neg;
  logic [N-1:0]  a_mag;
  logic [N-1:0]  b_mag;
  logic [N-1:0]  rem_nx;
  logic [N-1:0]  quo_nx;

  // Magnitudes of the operands; the most negative value maps onto itself,
  // which is already the correct unsigned magnitude.
  assign div_signed = (Op == OP_DIV);
  assign a_neg      = div_signed & A[N-1];
  assign b_neg      = div_signed & B[N-1];
  assign a_mag      = a_neg ? (~A + 1'b1) : A;
  assign b_mag      = b_neg ? (~B + 1'b1) : B;

  div_restoring_step #(.N(N)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvs      (dvs_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  // Control FSM and HI/LO update: accept ops in IDLE, iterate in RUN, sign-fix in FIX.
  always_ff @(posedge Clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (Rst) begin
      state     <= S_IDLE;
      count     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo   <= 1'b0;
      neg_rem   <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            case (Op)
              OP_MULT, OP_MULTU: begin
                Hi   <= ProdHi;
                Lo   <= ProdLo;
                Done <= 1'b1;
              end
              OP_MTHI: begin
                Hi   <= A;
                Done <= 1'b1;
              end
              OP_MTLO: begin
                Lo   <= A;
                Done <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                if (B == '0) begin
                  Hi        <= A;
                  Lo        <= '1;
                  Done      <= 1'b1;
                  DivByZero <= 1'b1;
                end else begin
                  rem_q   <= '0;
                  quo_q   <= a_mag;
                  dvs_q   <= b_mag;
                  neg_quo <= a_neg ^ b_neg;
                  neg_rem <= a_neg;
                  count   <= CW'(N);
                  Busy    <= 1'b1;
                  state   <= S_RUN;
                end
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          count <= count - 1'b1;
          if (count == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          Lo    <= neg_quo ? (~quo_q + 1'b1) : quo_q;
          Hi    <= neg_rem ? (~rem_q + 1'b1) : rem_q;
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`else

  // Without the divider the divisor operand has no consumer.
  logic unused_b;
  assign unused_b = ^B;

  assign Busy = 1'b0;

  // Single-cycle HI/LO update; DIV/DIVU only acknowledge.
  always_ff @(posedge Clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    if (Rst) begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      if (Start) begin
        case (Op)
          OP_MULT, OP_MULTU: begin
            Hi   <= ProdHi;
            Lo   <= ProdLo;
            Done <= 1'b1;
          end
          OP_MTHI: begin
            Hi   <= A;
            Done <= 1'b1;
          end
          OP_MTLO: begin
            Lo   <= A;
            Done <= 1'b1;
          end
          OP_DIV, OP_DIVU: Done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

`endif

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Sequential HI/LO register unit sitting directly downstream of the combinational N-bit multiplier in the CPU datapath. It drives the multiplier's signedness select, captures its {OutHi, OutLo} product into architectural HI/LO registers, and runs a multi-cycle restoring divider for DIV/DIVU. It also services MTHI/MTLO writes, and exposes Busy so the pipeline stalls on HI/LO reads while a division is in flight.

## Interface
- N, 32, operand/register width (≥ 2)
- Clk  in  1  clock, all state on rising edge
- Rst  in  1  reset, synchronous, active-high
- Start  in  1  operation request; accepted only when Busy=0
- Op  in  3  operation code (hilo_pkg encoding)
- A  in  N  multiplicand / dividend / MTHI-MTLO data
- B  in  N  multiplier / divisor
- ProdHi  in  N  upper product from upstream multiplier, fed A,B in the same cycle
- ProdLo  in  N  lower product from upstream multiplier
- MulSigned  out  1  combinational; 1 when Op=OP_MULT, drives multiplier Signed
- Busy  out  1  division in progress
- Done  out  1  one-cycle pulse; Hi/Lo hold the new result in the same cycle
- DivByZero  out  1  one-cycle pulse coincident with Done of a divide with B=0
- Hi  out  N  HI register
- Lo  out  N  LO register

## Operation
- Ops: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO; other codes are no-ops (no Done).
- States: IDLE, RUN, FIX.
- IDLE + Start + MULT/MULTU: Hi←ProdHi, Lo←ProdLo; Done next cycle.
- IDLE + Start + MTHI/MTLO: Hi←A or Lo←A only; Done next cycle.
- IDLE + Start + DIV/DIVU with B=0: Hi←A, Lo←all ones, Done and DivByZero next cycle, stay IDLE.
- IDLE + Start + DIV/DIVU with B≠0: latch |A|, |B| (magnitudes only when DIV), sign flags, count←N → RUN.
- RUN: one restoring step per cycle (shift remainder/quotient, trial subtract, set quotient bit); count decrements; at count=1 → FIX.
- FIX: negate quotient if signs differ, negate remainder if dividend negative; Lo←quotient, Hi←remainder; → IDLE with Done.
- Signed results: quotient truncates toward zero, remainder takes dividend sign.
- Overflow DIV of MIN by −1: Lo=MIN, Hi=0 (two's-complement wrap, no flag).
- Start while Busy=1: ignored, no state change.
- Hi/Lo never change except at a completing operation.

## Timing
- Reset values: Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0, state IDLE, count=0.
- Rst mid-division: abort, all outputs to reset values next cycle; no Done.
- Start accepted at edge ending cycle t.
- MULT/MULTU/MTHI/MTLO/divide-by-zero: Done=1 and new Hi/Lo in cycle t+1; latency 1.
- DIV/DIVU: Busy=1 in cycles t+1..t+N+1 (N RUN + 1 FIX); Done=1, new Hi/Lo, Busy=0 in cycle t+N+2.
- Back-to-back: new Start accepted in the Done cycle.
- Busy, Done, DivByZero registered; MulSigned combinational from Op.

## Configuration
- HILO_DIV_EN defined: divider present as above.
- Undefined: no RUN/FIX datapath; DIV/DIVU complete in 1 cycle with Done=1, Hi/Lo unchanged, DivByZero=0; Busy tied 0.

## Structure
- hilo_pkg: Op width, OP_* localparams, state enum type.
- One sub-module: div_restoring_step, combinational single iteration (remainder, quotient, divisor in; next remainder, quotient out), instantiated once in RUN datapath.
- Multiplier stays external; this block only consumes its product.

## Test plan
- MULT A=0xFFFFFFFE, B=3 (product ports driven by real multiplier) -> MulSigned=1, cycle t+1: Hi=0xFFFFFFFF, Lo=0xFFFFFFFA, Done=1.
- MULTU same operands -> MulSigned=0, Hi=0x00000002, Lo=0xFFFFFFFA.
- DIVU A=100, B=7 -> Busy t+1..t+33, cycle t+34: Lo=14, Hi=2, Done=1; DIV A=−7, B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
- DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0; DIV A=5, B=0 -> cycle t+1 Hi=5, Lo=0xFFFFFFFF, DivByZero=1.
- Start MTHI A=0x1234 during division at t+5 -> ignored, Hi unchanged until division Done; MTHI after Done -> Hi=0x1234, Lo unchanged.
- Rst at cycle t+10 of a DIVU -> cycle t+11: Busy=0, Hi=Lo=0, no Done pulse ever follows.
